// File: rtl/ir_alu_if.sv
// ir_alu_if
// Groups the instruction, GPR side-port and result signals of ir_alu_core.
//   master : drives instr_valid/instr, the GPR side-port write and the read
//            address; observes gpr_rd_data, ir_q, result, result_valid, sgpr.
//   slave  : the execute core itself (mirror directions).
interface ir_alu_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        gpr_wr_en;
  logic [4:0]  gpr_wr_addr;
  logic [15:0] gpr_wr_data;
  logic [4:0]  gpr_rd_addr;
  logic [15:0] gpr_rd_data;
  logic [31:0] ir_q;
  logic [15:0] result;
  logic        result_valid;
  logic [15:0] sgpr;

  modport master (
    output instr_valid, instr, gpr_wr_en, gpr_wr_addr, gpr_wr_data, gpr_rd_addr,
    input  gpr_rd_data, ir_q, result, result_valid, sgpr
  );

  modport slave (
    input  instr_valid, instr, gpr_wr_en, gpr_wr_addr, gpr_wr_data, gpr_rd_addr,
    output gpr_rd_data, ir_q, result, result_valid, sgpr
  );
endinterface

// File: rtl/ir_alu_core.sv
// ir_alu_core
// Instruction register plus ALU execute stage. An accepted instruction is
// latched into IR on one edge and executed against the 32 x 16-bit GPR file
// (and SGPR, the upper half of multiply products) on the following edge.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears IR, GPRs, SGPR, result
//   bus   : ir_alu_if.slave -- instruction input, GPR side port
//           (write/combinational read), ir_q, result/result_valid, sgpr
module ir_alu_core (
  input  logic      clk,
  input  logic      rst_n,
  ir_alu_if.slave   bus
);
  localparam int DATA_W = 16;

  typedef enum logic [4:0] {
    OP_MOVSGPR = 5'd0,
    OP_MOV     = 5'd1,
    OP_ADD     = 5'd2,
    OP_SUB     = 5'd3,
    OP_MUL     = 5'd4,
    OP_OR      = 5'd5,
    OP_AND     = 5'd6,
    OP_XOR     = 5'd7,
    OP_XNOR    = 5'd8,
    OP_NAND    = 5'd9,
    OP_NOR     = 5'd10,
    OP_NOT     = 5'd11
  } op_e;

  logic [31:0]       ir_p0;
  logic              vld_p0;
  logic [DATA_W-1:0] gpr [32];
  logic [DATA_W-1:0] sgpr_q;
  logic [DATA_W-1:0] result_p1;
  logic              vld_p1;

  logic [4:0]          oper_type;
  logic [4:0]          rdst;
  logic [4:0]          rsrc1;
  logic                mode;
  logic [4:0]          rsrc2;
  logic [DATA_W-1:0]   isrc;
  logic [DATA_W-1:0]   src1;
  logic [DATA_W-1:0]   src2;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   alu_res;
  logic                wr_gpr;
  logic                wr_sgpr;

  assign oper_type = ir_p0[31:27];
  assign rdst      = ir_p0[26:22];
  assign rsrc1     = ir_p0[21:17];
  assign mode      = ir_p0[16];
  assign rsrc2     = ir_p0[15:11];
  assign isrc      = ir_p0[15:0];

  assign src1 = gpr[rsrc1];
  assign src2 = mode ? isrc : gpr[rsrc2];
  assign prod = {{DATA_W{1'b0}}, src1} * {{DATA_W{1'b0}}, src2};

  always_comb begin
    alu_res = '0;
    wr_gpr  = 1'b1;
    wr_sgpr = 1'b0;
    case (oper_type)
      OP_MOVSGPR: alu_res = sgpr_q;
      OP_MOV:     alu_res = mode ? isrc : src1;
      OP_ADD:     alu_res = src1 + src2;
      OP_SUB:     alu_res = src1 - src2;
      OP_MUL: begin
        alu_res = prod[DATA_W-1:0];
        wr_sgpr = 1'b1;
      end
      OP_OR:      alu_res = src1 | src2;
      OP_AND:     alu_res = src1 & src2;
      OP_XOR:     alu_res = src1 ^ src2;
      OP_XNOR:    alu_res = ~(src1 ^ src2);
      OP_NAND:    alu_res = ~(src1 & src2);
      OP_NOR:     alu_res = ~(src1 | src2);
      OP_NOT:     alu_res = mode ? ~isrc : ~src1;
      default:    wr_gpr  = 1'b0;   // opcodes 12..31 are NOPs
    endcase
  end

  // Stage p0: instruction register and execute flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_p0  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      if (bus.instr_valid) ir_p0 <= bus.instr;
      vld_p0 <= bus.instr_valid;
    end
  end

  // Stage p1: register-file / SGPR writeback and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
      sgpr_q    <= '0;
      result_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      if (bus.gpr_wr_en) gpr[bus.gpr_wr_addr] <= bus.gpr_wr_data;
      // Later assignment: the execute write overrides a same-address side write.
      if (vld_p0 && wr_gpr) begin
        gpr[rdst] <= alu_res;
        result_p1 <= alu_res;
      end
      if (vld_p0 && wr_sgpr) sgpr_q <= prod[2*DATA_W-1:DATA_W];
      vld_p1 <= vld_p0 && wr_gpr;
    end
  end

  assign bus.gpr_rd_data  = gpr[bus.gpr_rd_addr];
  assign bus.ir_q         = ir_p0;
  assign bus.result       = result_p1;
  assign bus.result_valid = vld_p1;
  assign bus.sgpr         = sgpr_q;
endmodule

// File: tb/tb_ir_alu_core.sv
module tb_ir_alu_core;
  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  ir_alu_if bus ();

  ir_alu_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic md,
                                     input logic [15:0] low);
    return {op, rd, rs1, md, low};
  endfunction

  function automatic logic [15:0] r2(input logic [4:0] rs2);
    return {rs2, 11'b0};
  endfunction

  task automatic rd_gpr(input logic [4:0] a, output logic [15:0] d);
    bus.gpr_rd_addr = a;
    #1;
    d = bus.gpr_rd_data;
  endtask

  task automatic wr_gpr(input logic [4:0] a, input logic [15:0] d);
    bus.gpr_wr_en   = 1'b1;
    bus.gpr_wr_addr = a;
    bus.gpr_wr_data = d;
    @(negedge clk);
    bus.gpr_wr_en   = 1'b0;
  endtask

  // Issue one instruction, wait until it has executed, check result and the pulse.
  task automatic exec(input string tag, input logic [31:0] ins, input logic [15:0] exp);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_vld"}, {31'b0, bus.result_valid}, 32'd1);
    chk({tag, "_res"}, {16'b0, bus.result}, {16'b0, exp});
    @(negedge clk);
    chk({tag, "_vld_drop"}, {31'b0, bus.result_valid}, 32'd0);
  endtask

  logic [15:0] d;

  initial begin
    errs = 0;
    checks = 0;
    bus.instr_valid = 1'b1;
    bus.instr       = 32'hFFFF_FFFF;
    bus.gpr_wr_en   = 1'b0;
    bus.gpr_wr_addr = '0;
    bus.gpr_wr_data = '0;
    bus.gpr_rd_addr = '0;
    rst_n = 1'b0;

    // Reset held with instr_valid active
    repeat (3) @(negedge clk);
    chk("rst_ir", bus.ir_q, 32'h0);
    chk("rst_sgpr", {16'b0, bus.sgpr}, 32'h0);
    chk("rst_vld", {31'b0, bus.result_valid}, 32'h0);
    chk("rst_result", {16'b0, bus.result}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rd_gpr(i[4:0], d);
      chk($sformatf("rst_gpr%0d", i), {16'b0, d}, 32'h0);
    end
    bus.instr_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    rd_gpr(5'd0, d);  chk("post_rst_gpr0", {16'b0, d}, 32'h0);
    rd_gpr(5'd31, d); chk("post_rst_gpr31", {16'b0, d}, 32'h0);
    chk("post_rst_vld", {31'b0, bus.result_valid}, 32'h0);

    // Immediate add
    for (int i = 0; i < 32; i++) wr_gpr(i[4:0], 16'd2);
    exec("addi", mk(5'd2, 5'd0, 5'd2, 1'b1, 16'd4), 16'd6);
    rd_gpr(5'd0, d); chk("addi_gpr0", {16'b0, d}, 32'd6);
    chk("addi_ir_hold", bus.ir_q, mk(5'd2, 5'd0, 5'd2, 1'b1, 16'd4));

    // Register-mode sub / logic
    wr_gpr(5'd3, 16'h00F0);
    wr_gpr(5'd4, 16'h0F0F);
    exec("sub",  mk(5'd3,  5'd10, 5'd3, 1'b0, r2(5'd4)), 16'hF1E1);
    rd_gpr(5'd10, d); chk("sub_gpr10", {16'b0, d}, 32'hF1E1);
    exec("and",  mk(5'd6,  5'd11, 5'd3, 1'b0, r2(5'd4)), 16'h0000);
    exec("or",   mk(5'd5,  5'd12, 5'd3, 1'b0, r2(5'd4)), 16'h0FFF);
    exec("xnor", mk(5'd8,  5'd13, 5'd3, 1'b0, r2(5'd4)), 16'hF000);
    exec("xor",  mk(5'd7,  5'd14, 5'd3, 1'b0, r2(5'd4)), 16'h0FFF);
    exec("nand", mk(5'd9,  5'd15, 5'd3, 1'b0, r2(5'd4)), 16'hFFFF);
    exec("nor",  mk(5'd10, 5'd16, 5'd3, 1'b0, r2(5'd4)), 16'hF000);
    exec("not",  mk(5'd11, 5'd17, 5'd3, 1'b0, 16'h0),    16'hFF0F);
    exec("noti", mk(5'd11, 5'd18, 5'd3, 1'b1, 16'h1234), 16'hEDCB);
    rd_gpr(5'd17, d); chk("not_gpr17", {16'b0, d}, 32'hFF0F);
    chk("sgpr_untouched", {16'b0, bus.sgpr}, 32'h0);

    // Multiply then movsgpr
    wr_gpr(5'd1, 16'h1234);
    exec("mul", mk(5'd4, 5'd6, 5'd1, 1'b1, 16'h0100), 16'h3400);
    chk("mul_sgpr", {16'b0, bus.sgpr}, 32'h0012);
    rd_gpr(5'd6, d); chk("mul_gpr6", {16'b0, d}, 32'h3400);
    exec("movsgpr", mk(5'd0, 5'd5, 5'd0, 1'b0, 16'h0), 16'h0012);
    rd_gpr(5'd5, d); chk("movsgpr_gpr5", {16'b0, d}, 32'h0012);
    // rdst == rsrc1: old value read, new one written
    exec("mov_self", mk(5'd1, 5'd20, 5'd6, 1'b0, 16'h0), 16'h3400);
    exec("add_self", mk(5'd2, 5'd20, 5'd20, 1'b0, r2(5'd20)), 16'h6800);

    // Back-to-back with dependency, then an illegal opcode
    bus.instr_valid = 1'b1;
    bus.instr = mk(5'd1, 5'd1, 5'd0, 1'b1, 16'd7);
    @(negedge clk);
    bus.instr = mk(5'd2, 5'd2, 5'd1, 1'b1, 16'd1);
    @(negedge clk);
    chk("b2b_mov_vld", {31'b0, bus.result_valid}, 32'd1);
    chk("b2b_mov_res", {16'b0, bus.result}, 32'd7);
    bus.instr = mk(5'd20, 5'd1, 5'd3, 1'b1, 16'hBEEF);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("b2b_add_vld", {31'b0, bus.result_valid}, 32'd1);
    chk("b2b_add_res", {16'b0, bus.result}, 32'd8);
    @(negedge clk);
    chk("nop_vld", {31'b0, bus.result_valid}, 32'd0);
    chk("nop_result_hold", {16'b0, bus.result}, 32'd8);
    rd_gpr(5'd1, d); chk("nop_gpr1", {16'b0, d}, 32'd7);
    rd_gpr(5'd2, d); chk("b2b_gpr2", {16'b0, d}, 32'd8);
    chk("ir_hold", bus.ir_q, mk(5'd20, 5'd1, 5'd3, 1'b1, 16'hBEEF));
    @(negedge clk);
    chk("idle_vld", {31'b0, bus.result_valid}, 32'd0);

    // Side-port write collides with execute write to r9
    bus.instr_valid = 1'b1;
    bus.instr = mk(5'd2, 5'd9, 5'd3, 1'b1, 16'h0010);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.gpr_wr_en   = 1'b1;
    bus.gpr_wr_addr = 5'd9;
    bus.gpr_wr_data = 16'hAAAA;
    @(negedge clk);
    bus.gpr_wr_en = 1'b0;
    chk("coll_res", {16'b0, bus.result}, 32'h0100);
    rd_gpr(5'd9, d); chk("coll_gpr9", {16'b0, d}, 32'h0100);

    // Side-port write to a different address on an execute edge
    bus.instr_valid = 1'b1;
    bus.instr = mk(5'd1, 5'd21, 5'd0, 1'b1, 16'h5555);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.gpr_wr_en   = 1'b1;
    bus.gpr_wr_addr = 5'd22;
    bus.gpr_wr_data = 16'h1111;
    @(negedge clk);
    bus.gpr_wr_en = 1'b0;
    rd_gpr(5'd21, d); chk("both_gpr21", {16'b0, d}, 32'h5555);
    rd_gpr(5'd22, d); chk("both_gpr22", {16'b0, d}, 32'h1111);

    // Asynchronous reset clears state immediately
    #2 rst_n = 1'b0;
    #1;
    rd_gpr(5'd21, d); chk("async_gpr21", {16'b0, d}, 32'h0);
    chk("async_sgpr", {16'b0, bus.sgpr}, 32'h0);
    chk("async_ir", bus.ir_q, 32'h0);
    chk("async_result", {16'b0, bus.result}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
